// File: rtl/score_display_ctrl.sv
// Converts a 14-bit game value to BCD one bit per cycle and then updates all four
// seven-segment patterns at once, so the displays never show a half-converted number.
module score_display_ctrl #(
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] value_in,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3
);

    localparam logic [6:0] SegBlank = 7'b1111111;
    localparam logic [6:0] SegDash  = 7'b0111111;

    typedef enum logic [1:0] {StIdle, StConvert, StLatch} state_t;

    state_t      state_q;
    logic [13:0] shift_q;
    logic [15:0] bcd_q;
    logic [3:0]  cnt_q;
    logic        ovf_q;

    logic [15:0] bcd_adj;
    logic [6:0]  seg_d [4];

    function automatic logic [6:0] seg7(input logic [3:0] digit);
        logic [6:0] seg;
        unique case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SegBlank;
        endcase
        return seg;
    endfunction

    // Add-3 correction on every nibble that would exceed 9 after the next shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            seg_d[i] = seg7(bcd_q[i*4 +: 4]);
        end
        if (ovf_q) begin
            for (int i = 0; i < 4; i++) begin
                seg_d[i] = SegDash;
            end
        end else if (BLANK_LZ != 0) begin
            // hex0 is always lit so that zero still shows a single "0".
            if (bcd_q[15:12] == 4'd0) begin
                seg_d[3] = SegBlank;
            end
            if (bcd_q[15:8] == 8'd0) begin
                seg_d[2] = SegBlank;
            end
            if (bcd_q[15:4] == 12'd0) begin
                seg_d[1] = SegBlank;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            shift_q  <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            hex0     <= SegBlank;
            hex1     <= SegBlank;
            hex2     <= SegBlank;
            hex3     <= SegBlank;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (load) begin
                        shift_q <= value_in;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= (value_in > 14'd9999);
                        busy    <= 1'b1;
                        state_q <= StConvert;
                    end
                end
                StConvert: begin
                    bcd_q   <= {bcd_adj[14:0], shift_q[13]};
                    shift_q <= {shift_q[12:0], 1'b0};
                    cnt_q   <= cnt_q + 4'd1;
                    if (cnt_q == 4'd13) begin
                        state_q <= StLatch;
                    end
                end
                StLatch: begin
                    hex0     <= seg_d[0];
                    hex1     <= seg_d[1];
                    hex2     <= seg_d[2];
                    hex3     <= seg_d[3];
                    overflow <= ovf_q;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state_q  <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Scoreboard bench: each accepted load pushes the expected display, and every done pulse
// pops one entry and compares it with the latched outputs.
module tb_score_display_ctrl;

    logic        clk;
    logic        rst;
    logic [13:0] value_in;
    logic        load;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [6:0]  hex0;
    logic [6:0]  hex1;
    logic [6:0]  hex2;
    logic [6:0]  hex3;

    int n_checks;
    int n_pass;
    int done_cnt;
    logic [28:0] sb_q[$];
    logic [6:0] seg_tab [10];

    score_display_ctrl #(
        .BLANK_LZ(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .value_in (value_in),
        .load     (load),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .hex0     (hex0),
        .hex1     (hex1),
        .hex2     (hex2),
        .hex3     (hex3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {overflow, hex3, hex2, hex1, hex0} with leading zeros blanked.
    function automatic logic [28:0] model(input int v);
        logic [6:0] h [4];
        int d [4];
        if (v > 9999) begin
            return {1'b1, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
        end
        d[0] = v % 10;
        d[1] = (v / 10) % 10;
        d[2] = (v / 100) % 10;
        d[3] = v / 1000;
        for (int i = 0; i < 4; i++) begin
            h[i] = seg_tab[d[i]];
        end
        if (v < 1000) h[3] = 7'b1111111;
        if (v < 100)  h[2] = 7'b1111111;
        if (v < 10)   h[1] = 7'b1111111;
        return {1'b0, h[3], h[2], h[1], h[0]};
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                check_eq("done_unexpected", 32'(done), 32'd0);
            end else begin
                check_eq("display", 32'({overflow, hex3, hex2, hex1, hex0}), 32'(sb_q.pop_front()));
            end
        end
    end

    // Drive load for exactly one edge; returns #1 after that edge.
    task automatic do_load(input int v);
        value_in = 14'(v);
        load     = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        sb_q.push_back(model(v));
    endtask

    task automatic wait_done();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check_eq("done_timeout", 32'(got), 32'd1);
        @(negedge clk);
        #1;
    endtask

    initial begin
        int cnt0;
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        n_checks = 0;
        n_pass   = 0;
        done_cnt = 0;
        rst      = 1'b1;
        load     = 1'b0;
        value_in = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_hex", 32'({hex3, hex2, hex1, hex0}), 32'h0fffffff);
        rst = 1'b0;
        @(negedge clk);

        // 1234 with cycle-exact latency; hex must hold dark until the latch
        do_load(1234);
        check_eq("busy_k", 32'(busy), 32'd1);
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk);
            #1;
            check_eq("busy_conv", 32'({busy, done}), 32'b10);
            check_eq("hex_hold", 32'({hex3, hex2, hex1, hex0}), 32'h0fffffff);
        end
        @(posedge clk);
        #1;
        check_eq("latch_k15", 32'({busy, done}), 32'b01);

        // Back-to-back: load during the done cycle is accepted
        do_load(0);
        check_eq("b2b_busy", 32'(busy), 32'd1);
        check_eq("b2b_done_drop", 32'(done), 32'd0);
        wait_done();

        do_load(1005);
        wait_done();
        do_load(7);
        wait_done();
        do_load(12000);
        wait_done();
        check_eq("ovf_set", 32'(overflow), 32'd1);
        do_load(16383);
        wait_done();
        do_load(9999);
        wait_done();
        check_eq("ovf_clr", 32'(overflow), 32'd0);
        do_load(10000);
        wait_done();
        do_load(80);
        wait_done();

        // Load while busy is ignored
        cnt0 = done_cnt;
        do_load(42);
        repeat (4) @(posedge clk);
        #1;
        value_in = 14'd77;
        load     = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        check_eq("busy_ignore", 32'(busy), 32'd1);
        wait_done();
        repeat (20) @(posedge clk);
        #1;
        check_eq("one_done", 32'(done_cnt - cnt0), 32'd1);

        // Reset mid-conversion aborts with no done
        cnt0 = done_cnt;
        do_load(5678);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb_q.delete();
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_hex", 32'({hex3, hex2, hex1, hex0}), 32'h0fffffff);
        rst = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check_eq("abort_no_done", 32'(done_cnt - cnt0), 32'd0);
        check_eq("abort_idle", 32'(busy), 32'd0);

        // Recovery after abort
        do_load(305);
        wait_done();
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
